// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic {CTRL_RUN, CTRL_MC_WAIT} hz_state_t;

    // True when an operand is actually read and names the given register.
    function automatic logic src_hit(
        input logic                 uses,
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] rd
    );
        return uses && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute observation signals and pipeline stall/flush controls.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_reg_wr_en;
    logic                 ex_mem_to_reg;
    logic                 ex_redirect;
    logic                 ex_mc_start;
    logic                 mc_done;

    logic                 pc_en;
    logic                 if_id_stall;
    logic                 if_id_flush;
    logic                 id_ex_stall;
    logic                 id_ex_flush;
    logic                 ex_mem_stall;
    logic                 ex_mem_flush;
    logic                 mc_busy;

    // Pipeline side: reports stage contents, consumes controls.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_reg_wr_en, ex_mem_to_reg, ex_redirect,
               ex_mc_start, mc_done,
        input  pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mc_busy
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_reg_wr_en, ex_mem_to_reg, ex_redirect,
               ex_mc_start, mc_done,
        output pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mc_busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count up, stick at all-ones, clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: load-use, redirects and multi-cycle EX ops.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_t state_q;
    hz_state_t state_d;

    logic load_use;
    logic mc_hold;
    logic redirect_acc;

    logic pc_en_c;
    logic if_id_stall_c;
    logic if_id_flush_c;
    logic id_ex_stall_c;
    logic id_ex_flush_c;
    logic ex_mem_flush_c;

    // Hazard terms; writes to x0 never create a dependency.
    always_comb begin
        load_use = hz.ex_mem_to_reg && hz.ex_reg_wr_en && (hz.ex_rd != '0) &&
                   (src_hit(hz.id_uses_rs1, hz.id_rs1, hz.ex_rd) ||
                    src_hit(hz.id_uses_rs2, hz.id_rs2, hz.ex_rd));
        mc_hold  = hz.ex_mc_start && !hz.mc_done;
    end

    // State register; reset aborts any pending multi-cycle wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CTRL_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Mealy controls; reset forces everything quiet.
    always_comb begin
        state_d        = state_q;
        pc_en_c        = 1'b1;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        redirect_acc   = 1'b0;
        if (rst) begin
            state_d = CTRL_RUN;
            pc_en_c = 1'b0;
        end else begin
            case (state_q)
                CTRL_RUN: begin
                    if (mc_hold) begin
                        // Freeze front end, bubble into MEM; a same-cycle redirect is dropped.
                        pc_en_c        = 1'b0;
                        if_id_stall_c  = 1'b1;
                        id_ex_stall_c  = 1'b1;
                        ex_mem_flush_c = 1'b1;
                        state_d        = CTRL_MC_WAIT;
                    end else if (hz.ex_redirect) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        redirect_acc  = 1'b1;
                    end else if (load_use) begin
                        pc_en_c       = 1'b0;
                        if_id_stall_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                end
                CTRL_MC_WAIT: begin
                    if (!hz.mc_done) begin
                        pc_en_c        = 1'b0;
                        if_id_stall_c  = 1'b1;
                        id_ex_stall_c  = 1'b1;
                        ex_mem_flush_c = 1'b1;
                    end else begin
                        state_d = CTRL_RUN;
                    end
                end
                default: state_d = CTRL_RUN;
            endcase
        end
    end

    assign hz.pc_en        = pc_en_c;
    assign hz.if_id_stall  = if_id_stall_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_stall  = id_ex_stall_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.ex_mem_stall = 1'b0;
    assign hz.ex_mem_flush = ex_mem_flush_c;
    assign hz.mc_busy      = (state_q == CTRL_MC_WAIT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (!pc_en_c),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (redirect_acc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Vector table plus hand sequences; expected controls queued at drive, checked at sample.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TB_CNT_W = 4;

    // Expected control words: {pc_en, if_id_stall, if_id_flush, id_ex_stall,
    //                          id_ex_flush, ex_mem_stall, ex_mem_flush, mc_busy}
    localparam logic [7:0] C_RUN = 8'b1000_0000;
    localparam logic [7:0] C_LU  = 8'b0100_1000;
    localparam logic [7:0] C_RD  = 8'b1010_1000;
    localparam logic [7:0] C_MCH = 8'b0101_0010;
    localparam logic [7:0] C_MCW = 8'b0101_0011;
    localparam logic [7:0] C_MCD = 8'b1000_0001;
    localparam logic [7:0] C_RST = 8'b0000_0000;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       rdr;
        logic       mcs;
        logic       mcd;
        logic       clr;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] ctl;
    } sb_t;

    logic clk;
    logic rst;
    logic perf_clr;
    logic [TB_CNT_W-1:0] stall_cycles;
    logic [TB_CNT_W-1:0] flush_count;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hz),
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    sb_t exp_q[$];
    vec_t tbl[$];
    logic [TB_CNT_W-1:0] m_stall = '0;
    logic [TB_CNT_W-1:0] m_flush = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic ld, input logic rdr,
                                input logic mcs, input logic mcd, input logic clr,
                                input logic [7:0] exp);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.wr = wr; v.ld = ld; v.rdr = rdr; v.mcs = mcs; v.mcd = mcd; v.clr = clr;
        v.exp = exp;
        return v;
    endfunction

    // Drive inputs, queue the expected controls and advance the counter model.
    task automatic drive(input vec_t v);
        sb_t e;
        hz.id_rs1 = v.rs1; hz.id_rs2 = v.rs2;
        hz.id_uses_rs1 = v.u1; hz.id_uses_rs2 = v.u2;
        hz.ex_rd = v.rd; hz.ex_reg_wr_en = v.wr; hz.ex_mem_to_reg = v.ld;
        hz.ex_redirect = v.rdr; hz.ex_mc_start = v.mcs; hz.mc_done = v.mcd;
        perf_clr = v.clr;
        e.name = v.name; e.ctl = v.exp;
        exp_q.push_back(e);
        if (!rst) begin
            if (v.clr) begin
                m_stall = '0;
                m_flush = '0;
            end else begin
                if (!v.exp[7] && m_stall != '1) m_stall = m_stall + 4'd1;
                if (v.exp[5] && m_flush != '1) m_flush = m_flush + 4'd1;
            end
        end
    endtask

    // Pop the oldest expectation and compare against the live controls.
    task automatic compare_ctl();
        sb_t e;
        logic [7:0] act;
        act = {hz.pc_en, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
               hz.id_ex_flush, hz.ex_mem_stall, hz.ex_mem_flush, hz.mc_busy};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: ctl got %b, nothing expected", act);
        end else begin
            e = exp_q.pop_front();
            if (act === e.ctl) n_pass++;
            else $display("FAIL %s: ctl got %b want %b", e.name, act, e.ctl);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_ctl();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        sample();
        step();
    endtask

    task automatic chk_cnt(input string name, input logic [TB_CNT_W-1:0] act,
                           input logic [TB_CNT_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: count got %0d want %0d", name, act, exp);
    endtask

    task automatic chk_counters(input string tag);
        chk_cnt({tag, "_stall"}, stall_cycles, m_stall);
        chk_cnt({tag, "_flush"}, flush_count, m_flush);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);

        tbl.push_back(mk("t_idle",        5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));
        tbl.push_back(mk("t_lu_rs1",      5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU));
        tbl.push_back(mk("t_after_lu",    5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));
        tbl.push_back(mk("t_x0",          5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));
        tbl.push_back(mk("t_rs2_unused",  5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));
        tbl.push_back(mk("t_lu_rs2",      5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU));
        tbl.push_back(mk("t_ld_no_wr",    5'd9, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));
        tbl.push_back(mk("t_rdr_over_lu", 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_RD));
        tbl.push_back(mk("t_rdr",         5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RD));
        tbl.push_back(mk("t_mc_zero",     5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_RUN));
        tbl.push_back(mk("t_done_stray",  5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_RUN));
        tbl.push_back(mk("t_mc_zero_lu",  5'd3, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_LU));
        tbl.push_back(mk("t_mc_over_rdr", 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_MCH));
        tbl.push_back(mk("t_wait_ignore", 5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_MCW));
        tbl.push_back(mk("t_wait_done",   5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_MCD));
        tbl.push_back(mk("t_back_run",    5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));

        // Reset with a load-use pattern present: controls quiet, counters zero.
        rst = 1'b1;
        drive(mk("rst_hold", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_RST));
        sample();
        step();
        chk_counters("rst");
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);
        chk_counters("table");

        // Multi-cycle op, done arriving 4 cycles after start.
        idle.clr = 1'b1; idle.name = "mc_clr";
        apply(idle);
        idle.clr = 1'b0; idle.name = "idle";
        chk_counters("mc_clr");
        apply(mk("mc_c1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCH));
        for (int i = 0; i < 3; i++)
            apply(mk("mc_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCW));
        apply(mk("mc_c5", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_MCD));
        apply(mk("mc_c6", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));
        chk_cnt("mc_stall4", stall_cycles, 4'd4);

        // Reset asserted in the second MC_WAIT cycle.
        idle.clr = 1'b1;
        apply(idle);
        idle.clr = 1'b0;
        apply(mk("rw_c1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCH));
        apply(mk("rw_w1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCW));
        drive(mk("rw_w2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCW));
        sample();
        chk_cnt("rw_pre_stall", stall_cycles, 4'd2);
        #1;
        rst = 1'b1;
        m_stall = '0;
        m_flush = '0;
        #1;
        exp_q.push_back('{name: "rw_rst_now", ctl: C_RST});
        compare_ctl();
        chk_counters("rw_rst_now");
        step();
        exp_q.push_back('{name: "rw_rst_edge", ctl: C_RST});
        compare_ctl();
        rst = 1'b0;
        apply(mk("rw_rel", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN));
        apply(mk("rw_restart", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCH));
        apply(mk("rw_done", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_MCD));
        chk_counters("rw_after");

        // Saturation over a 20-cycle load-use stall, then clear while stalling.
        idle.clr = 1'b1;
        apply(idle);
        idle.clr = 1'b0;
        for (int i = 0; i < 20; i++)
            apply(mk("sat_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU));
        chk_cnt("sat_15", stall_cycles, 4'd15);
        apply(mk("sat_clr", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_LU));
        chk_cnt("sat_clr0", stall_cycles, 4'd0);
        apply(mk("sat_lu2", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU));
        chk_counters("sat_after");

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage RV32 core. It watches the decode and execute stages and drives the stall/flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, control-flow redirects and multi-cycle EX operations such as mul/div. It also keeps saturating performance counters for stall cycles and redirect flushes.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  5  rs1 index of the instruction in ID
- id_rs2  in  5  rs2 index of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination index of the instruction in EX
- ex_reg_wr_en  in  1  EX instruction writes rd
- ex_mem_to_reg  in  1  EX instruction is a load
- ex_redirect  in  1  branch taken or jal/jalr resolved in EX this cycle
- ex_mc_start  in  1  multi-cycle op present in EX and not yet complete
- mc_done  in  1  multi-cycle unit result valid this cycle
- perf_clr  in  1  synchronous clear of both counters
- pc_en  out  1  PC register load enable
- if_id_stall, if_id_flush  out  1 each  IF/ID controls
- id_ex_stall, id_ex_flush  out  1 each  ID/EX controls
- ex_mem_stall, ex_mem_flush  out  1 each  EX/MEM controls
- mc_busy  out  1  FSM is in MC_WAIT
- stall_cycles  out  CNT_W  count of cycles with pc_en=0
- flush_count  out  CNT_W  count of redirect events

## Operation
- Pipeline registers hold when stall=1 and ignore flush while stalled. This block never asserts stall and flush together on the same register.
- The FSM has two states: RUN and MC_WAIT.
- Hazard terms:
  - load_use = ex_mem_to_reg & ex_reg_wr_en & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - mc_hold = ex_mc_start & ~mc_done.
- Priority in RUN (highest first):
  1. mc_hold: pc_en=0, if_id_stall=1, id_ex_stall=1, ex_mem_flush=1. A bubble enters MEM. Next state is MC_WAIT.
  2. ex_redirect: pc_en=1 (PC loads the target), if_id_flush=1, id_ex_flush=1. flush_count increments.
  3. load_use: pc_en=0, if_id_stall=1, id_ex_flush=1. A one-cycle bubble enters EX.
  4. Otherwise: pc_en=1 and all stalls and flushes are 0.
- ex_redirect with ex_mc_start in the same cycle is illegal by decode. If it occurs anyway, mc_hold wins and the redirect is dropped.
- A zero-wait op (ex_mc_start & mc_done in RUN) is not a hold. It falls through to the lower priorities.
- MC_WAIT behaviour:
  - mc_done=0: same outputs as mc_hold.
  - mc_done=1: all stalls and flushes are 0, pc_en=1, next state is RUN. The result advances to EX/MEM.
  - ex_redirect and load_use are ignored.
- mc_done while in RUN with no ex_mc_start is ignored.
- ex_mem_stall is tied 0 in this revision. The port is reserved for a future D-cache miss.
- Counters saturate at all-ones.
  - stall_cycles increments on every cycle with pc_en=0.
  - flush_count increments on every accepted redirect.
  - perf_clr has priority over increment; counters read 0 in the next cycle.

## Timing
- All control outputs are combinational (Mealy) from the current state and the inputs, and are valid in the same cycle. The state and counters are registered.
- While rst is asserted:
  - State is RUN.
  - pc_en=0; all stall, flush and mc_busy outputs are 0.
  - Counters are 0.
- The first edge after rst deasserts evaluates normally.
- Reset asserted in MC_WAIT aborts the wait immediately. After release the FSM is in RUN.
- Load-use costs exactly 1 bubble.
- A redirect costs 2 flushed slots (IF/ID and ID/EX) in 1 cycle.
- A multi-cycle op with mc_done arriving N cycles after ex_mc_start first rises stalls the pipeline for exactly N cycles.
- mc_busy is registered: high from the cycle after entry to MC_WAIT until the cycle after mc_done.

## Structure
- Add to the shared package all_pkgs: `typedef enum logic {CTRL_RUN, CTRL_MC_WAIT} hz_state_t;`.
- One sub-module, sat_counter (parameter CNT_W; ports clk, rst, clr, inc, count), instantiated twice.
- The hazard compare and the FSM live in pipe_hazard_ctrl.

## Test plan
- Load-use: EX lw with rd=5 and ID add with rs1=5. Expect one cycle with pc_en=0, if_id_stall=1, id_ex_flush=1, then the normal run. stall_cycles=1.
- x0 and unused operands: EX lw with rd=0 and ID rs1=0 → no stall. EX lw with rd=7 and ID rs2=7 but id_uses_rs2=0 → no stall.
- Redirect over load-use: ex_redirect=1 and load_use true in the same cycle. Expect pc_en=1, if_id_flush=1, id_ex_flush=1, no stall. flush_count=1.
- Multi-cycle: ex_mc_start rises and mc_done arrives 4 cycles later. Expect 4 stalled cycles with ex_mem_flush=1, mc_busy high for cycles 2–5, and stall_cycles=4. Also drive ex_mc_start with mc_done in the same cycle and expect zero stalls.
- Reset mid-wait: assert rst in the 2nd MC_WAIT cycle. Expect all outputs quiescent and counters at 0 immediately, and RUN state after release.
- Saturation and clear: with CNT_W=4, hold a stall for 20 cycles. Expect stall_cycles=15. Pulse perf_clr with a stall active and expect 0 in the next cycle.
